// File: rtl/dcache_ctrl_nway.sv
// dcache_ctrl_nway: control FSM for an N-way, write-back, write-allocate data
// cache with multi-word lines. It turns MEM-stage requests into array write
// strobes, LRU updates and burst memory beats. Outputs are decoded directly
// from the current state and inputs, so a hit completes in the request cycle.
module dcache_ctrl_nway #(
    parameter int WAYS       = 2,
    parameter int LINE_WORDS = 4,
    parameter int WAY_W      = $clog2(WAYS),
    parameter int BEAT_W     = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        req_op,
    input  logic [WAY_W-1:0]  idx_way,
    input  logic [WAYS-1:0]   hit_vec,
    input  logic [WAYS-1:0]   valid_vec,
    input  logic [WAYS-1:0]   dirty_vec,
    input  logic [WAY_W-1:0]  lru_way,
    input  logic              mem_ack,
    output logic              req_ready,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic              mem_addr_sel,
    output logic [BEAT_W-1:0] beat,
    output logic [WAY_W-1:0]  sel_way,
    output logic [WAYS-1:0]   data_we,
    output logic              data_src,
    output logic [WAYS-1:0]   tag_we,
    output logic [WAYS-1:0]   valid_we,
    output logic              valid_wdata,
    output logic [WAYS-1:0]   dirty_we,
    output logic              dirty_wdata,
    output logic              lru_touch,
    output logic [WAY_W-1:0]  lru_touch_way
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WB      = 3'd1;
    localparam logic [2:0] S_FILL    = 3'd2;
    localparam logic [2:0] S_INSTALL = 3'd3;
    localparam logic [2:0] S_MAINT   = 3'd4;

    localparam logic [2:0] OP_READ     = 3'b001;
    localparam logic [2:0] OP_WRITE    = 3'b010;
    localparam logic [2:0] OP_IDX_INV  = 3'b011;
    localparam logic [2:0] OP_ADDR_INV = 3'b100;
    localparam logic [2:0] OP_WB_INV   = 3'b101;
    localparam logic [2:0] OP_WB_CLEAN = 3'b110;

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

    // Index of the lowest set bit; 0 when the vector is empty.
    function automatic logic [WAY_W-1:0] low_idx(input logic [WAYS-1:0] v);
        logic [WAY_W-1:0] idx;
        idx = {WAY_W{1'b0}};
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = WAY_W'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // One-hot decode of a way index.
    function automatic logic [WAYS-1:0] onehot(input logic [WAY_W-1:0] w);
        logic [WAYS-1:0] oh;
        oh    = {WAYS{1'b0}};
        oh[w] = 1'b1;
        return oh;
    endfunction

    logic [2:0]        state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [WAY_W-1:0]  victim_q, victim_d;
    logic              maint_q, maint_d;

    logic              hit_any_s;
    logic [WAY_W-1:0]  hit_way_s;
    logic              hit_dirty_s;
    logic [WAYS-1:0]   invalid_s;
    logic [WAY_W-1:0]  victim_s;
    logic              victim_dirty_s;
    logic              last_beat_s;

    // Multiple hits are illegal; the lowest-index way wins.
    assign hit_any_s      = |hit_vec;
    assign hit_way_s      = low_idx(hit_vec);
    assign hit_dirty_s    = hit_any_s & dirty_vec[hit_way_s];
    // Prefer filling an empty way; only evict the LRU way when the set is full.
    assign invalid_s      = ~valid_vec;
    assign victim_s       = (|invalid_s) ? low_idx(invalid_s) : lru_way;
    assign victim_dirty_s = valid_vec[victim_s] & dirty_vec[victim_s];
    assign last_beat_s    = mem_ack & (beat_q == LAST_BEAT);

    // Next-state and output decode for every controller state.
    always_comb begin
        state_d       = state_q;
        beat_d        = beat_q;
        victim_d      = victim_q;
        maint_d       = maint_q;
        req_ready     = 1'b0;
        mem_rd        = 1'b0;
        mem_wr        = 1'b0;
        mem_addr_sel  = 1'b0;
        beat          = beat_q;
        sel_way       = {WAY_W{1'b0}};
        data_we       = {WAYS{1'b0}};
        data_src      = 1'b0;
        tag_we        = {WAYS{1'b0}};
        valid_we      = {WAYS{1'b0}};
        valid_wdata   = 1'b0;
        dirty_we      = {WAYS{1'b0}};
        dirty_wdata   = 1'b0;
        lru_touch     = 1'b0;
        lru_touch_way = {WAY_W{1'b0}};

        case (state_q)
            S_IDLE: begin
                case (req_op)
                    OP_READ, OP_WRITE: begin
                        if (hit_any_s) begin
                            req_ready     = 1'b1;
                            sel_way       = hit_way_s;
                            lru_touch     = 1'b1;
                            lru_touch_way = hit_way_s;
                            if (req_op == OP_WRITE) begin
                                data_we     = onehot(hit_way_s);
                                data_src    = 1'b1;
                                dirty_we    = onehot(hit_way_s);
                                dirty_wdata = 1'b1;
                            end else begin
                                data_we = {WAYS{1'b0}};
                            end
                        end else begin
                            victim_d = victim_s;
                            beat_d   = {BEAT_W{1'b0}};
                            if (victim_dirty_s) begin
                                maint_d = 1'b0;
                                state_d = S_WB;
                            end else begin
                                state_d = S_FILL;
                            end
                        end
                    end
                    OP_IDX_INV: begin
                        req_ready = 1'b1;
                        sel_way   = idx_way;
                        valid_we  = onehot(idx_way);
                    end
                    OP_ADDR_INV: begin
                        req_ready = 1'b1;
                        if (hit_any_s) begin
                            sel_way  = hit_way_s;
                            valid_we = onehot(hit_way_s);
                        end else begin
                            valid_we = {WAYS{1'b0}};
                        end
                    end
                    OP_WB_INV, OP_WB_CLEAN: begin
                        if (hit_any_s) begin
                            sel_way = hit_way_s;
                        end else begin
                            sel_way = {WAY_W{1'b0}};
                        end
                        if (hit_dirty_s) begin
                            victim_d = hit_way_s;
                            maint_d  = 1'b1;
                            beat_d   = {BEAT_W{1'b0}};
                            state_d  = S_WB;
                        end else begin
                            req_ready = 1'b1;
                            if (hit_any_s && (req_op == OP_WB_INV)) begin
                                valid_we = onehot(hit_way_s);
                            end else begin
                                valid_we = {WAYS{1'b0}};
                            end
                        end
                    end
                    default: begin
                        state_d = S_IDLE;
                    end
                endcase
            end
            S_WB: begin
                mem_wr       = 1'b1;
                mem_addr_sel = maint_q;
                sel_way      = victim_q;
                if (last_beat_s) begin
                    beat_d  = {BEAT_W{1'b0}};
                    state_d = maint_q ? S_MAINT : S_FILL;
                end else if (mem_ack) begin
                    beat_d = beat_q + 1'b1;
                end else begin
                    beat_d = beat_q;
                end
            end
            S_FILL: begin
                mem_rd       = 1'b1;
                mem_addr_sel = 1'b1;
                sel_way      = victim_q;
                if (mem_ack) begin
                    data_we = onehot(victim_q);
                end else begin
                    data_we = {WAYS{1'b0}};
                end
                if (last_beat_s) begin
                    beat_d  = {BEAT_W{1'b0}};
                    state_d = S_INSTALL;
                end else if (mem_ack) begin
                    beat_d = beat_q + 1'b1;
                end else begin
                    beat_d = beat_q;
                end
            end
            S_INSTALL: begin
                req_ready     = 1'b1;
                sel_way       = victim_q;
                tag_we        = onehot(victim_q);
                valid_we      = onehot(victim_q);
                valid_wdata   = 1'b1;
                dirty_we      = onehot(victim_q);
                dirty_wdata   = (req_op == OP_WRITE);
                lru_touch     = 1'b1;
                lru_touch_way = victim_q;
                if (req_op == OP_WRITE) begin
                    data_we  = onehot(victim_q);
                    data_src = 1'b1;
                end else begin
                    data_we = {WAYS{1'b0}};
                end
                state_d = S_IDLE;
            end
            S_MAINT: begin
                req_ready = 1'b1;
                sel_way   = victim_q;
                if (req_op == OP_WB_INV) begin
                    valid_we = onehot(victim_q);
                end else if (req_op == OP_WB_CLEAN) begin
                    dirty_we = onehot(victim_q);
                end else begin
                    valid_we = {WAYS{1'b0}};
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                beat_d  = {BEAT_W{1'b0}};
            end
        endcase

        // Reset quiesces everything; ready stays high so the pipeline is not stalled.
        if (rst) begin
            req_ready     = 1'b1;
            mem_rd        = 1'b0;
            mem_wr        = 1'b0;
            mem_addr_sel  = 1'b0;
            beat          = {BEAT_W{1'b0}};
            sel_way       = {WAY_W{1'b0}};
            data_we       = {WAYS{1'b0}};
            data_src      = 1'b0;
            tag_we        = {WAYS{1'b0}};
            valid_we      = {WAYS{1'b0}};
            valid_wdata   = 1'b0;
            dirty_we      = {WAYS{1'b0}};
            dirty_wdata   = 1'b0;
            lru_touch     = 1'b0;
            lru_touch_way = {WAY_W{1'b0}};
        end else begin
            req_ready = req_ready;
        end
    end

    // Controller state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            beat_q   <= {BEAT_W{1'b0}};
            victim_q <= {WAY_W{1'b0}};
            maint_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            victim_q <= victim_d;
            maint_q  <= maint_d;
        end
    end

endmodule
